// File: rtl/ysyx_23060124_issue_pkg.sv
// Shared definitions for the issue controller slice.
//   NR_REGS_DEF : architectural GPR count (RV32E)
//   RW_DEF      : register index width
//   CNT_W_DEF   : width of one scoreboard counter (max 2^CNT_W-1 writers in flight)
//   state_e     : issue FSM states
package ysyx_23060124_issue_pkg;

  localparam int NR_REGS_DEF = 16;
  localparam int RW_DEF      = $clog2(NR_REGS_DEF);
  localparam int CNT_W_DEF   = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,  // normal issue
    ST_WAIT_CF = 2'd1,  // control-flow instruction issued, waiting for redirect
    ST_DRAIN   = 2'd2,  // fence.i issued, waiting for the pipeline to empty
    ST_IFLUSH  = 2'd3   // I-cache flush requested, waiting for completion
  } state_e;

endpackage

// File: rtl/ysyx_23060124_scoreboard.sv
// Per-register count of in-flight GPR writes.
// Ports:
//   clock, reset             : clock and synchronous active-high reset
//   inc_valid / inc_idx      : one more writer of inc_idx has issued
//   dec_valid / dec_idx      : one writer of dec_idx has committed
//   rd1_idx / rd1_cnt        : read port 1 (registered count)
//   rd2_idx / rd2_cnt        : read port 2 (registered count)
//   sat_idx / sat            : counter of sat_idx is at its maximum
//   all_zero                 : no writes in flight anywhere
// Register 0 is never tracked; its counter stays at 0.
module ysyx_23060124_scoreboard
  import ysyx_23060124_issue_pkg::*;
#(
  parameter int  NR_REGS = NR_REGS_DEF,
  parameter int  CNT_W   = CNT_W_DEF,
  localparam int RW      = $clog2(NR_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc_valid,
  input  logic [RW-1:0]    inc_idx,
  input  logic             dec_valid,
  input  logic [RW-1:0]    dec_idx,
  input  logic [RW-1:0]    rd1_idx,
  output logic [CNT_W-1:0] rd1_cnt,
  input  logic [RW-1:0]    rd2_idx,
  output logic [CNT_W-1:0] rd2_cnt,
  input  logic [RW-1:0]    sat_idx,
  output logic             sat,
  output logic             all_zero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NR_REGS];
  logic [CNT_W-1:0] cnt_d [NR_REGS];

  always_comb begin
    for (int i = 0; i < NR_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i != 0) begin
        // A simultaneous increment and decrement of one entry cancel out.
        if (inc_valid && inc_idx == RW'(i) && !(dec_valid && dec_idx == RW'(i))) begin
          if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + 1'b1;
        end else if (dec_valid && dec_idx == RW'(i) && !(inc_valid && inc_idx == RW'(i))) begin
          // Underflow is illegal; hold at zero rather than wrap.
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NR_REGS; i++) begin
      if (reset) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NR_REGS; i++) begin
      if (cnt_q[i] != '0) all_zero = 1'b0;
    end
  end

  assign rd1_cnt = cnt_q[rd1_idx];
  assign rd2_cnt = cnt_q[rd2_idx];
  assign sat     = (cnt_q[sat_idx] == CNT_MAX);

endmodule

// File: rtl/ysyx_23060124_issue_ctrl.sv
// Issue controller between decode and execute.
// Owns the ID/EX valid bit, stalls on RAW hazards and writer saturation via a
// scoreboard, serialises control-flow instructions until redirect and
// sequences fence.i (drain -> I-cache flush -> wait for completion).
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   in_valid/in_ready                 : decoded instruction handshake
//   in_rs1/in_rs2/in_rd/in_wen        : operand and destination indices
//   in_ctrl, in_fence_i               : instruction class
//   id_load                           : load enable for the ID/EX payload register
//   out_valid/out_ready               : ID/EX -> EXU handshake
//   wb_valid/wb_rd                    : GPR write commit
//   redirect_valid                    : control instruction resolved
//   icache_flush/fencei_done          : I-cache flush request / completion
//   flush_if                          : discard fetched/decoded instruction
module ysyx_23060124_issue_ctrl
  import ysyx_23060124_issue_pkg::*;
#(
  parameter int  NR_REGS = NR_REGS_DEF,
  parameter int  CNT_W   = CNT_W_DEF,
  localparam int RW      = $clog2(NR_REGS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wen,
  input  logic          in_ctrl,
  input  logic          in_fence_i,
  output logic          id_load,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic          redirect_valid,
  output logic          icache_flush,
  input  logic          fencei_done,
  output logic          flush_if
);

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt;
  logic             rd_sat, sb_all_zero;
  logic             slot, hz, issue;

  ysyx_23060124_scoreboard #(
    .NR_REGS (NR_REGS),
    .CNT_W   (CNT_W)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .inc_valid (issue && in_wen && in_rd != '0),
    .inc_idx   (in_rd),
    .dec_valid (wb_valid && wb_rd != '0),
    .dec_idx   (wb_rd),
    .rd1_idx   (in_rs1),
    .rd1_cnt   (rs1_cnt),
    .rd2_idx   (in_rs2),
    .rd2_cnt   (rs2_cnt),
    .sat_idx   (in_rd),
    .sat       (rd_sat),
    .all_zero  (sb_all_zero)
  );

  // Hazards look only at registered counts: a write-back in this cycle does
  // not release a dependent instruction until the next cycle.
  assign slot  = !out_valid_q || out_ready;
  assign hz    = (in_rs1 != '0 && rs1_cnt != '0)
              || (in_rs2 != '0 && rs2_cnt != '0)
              || (in_wen && in_rd != '0 && rd_sat);
  assign issue = in_valid && slot && !hz && (state_q == ST_RUN);

  assign in_ready  = issue;
  assign id_load   = issue;
  assign out_valid = out_valid_q;

  always_comb begin
    state_d      = state_q;
    icache_flush = 1'b0;
    flush_if     = 1'b0;
    out_valid_d  = issue ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    case (state_q)
      ST_RUN: begin
        if (issue && in_ctrl)         state_d = ST_WAIT_CF;
        else if (issue && in_fence_i) state_d = ST_DRAIN;
      end
      ST_WAIT_CF: begin
        if (redirect_valid) begin
          flush_if = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Drained once the ID/EX slot is empty and no write is outstanding.
        if (!out_valid_q && sb_all_zero) begin
          icache_flush = 1'b1;
          state_d      = ST_IFLUSH;
        end
      end
      ST_IFLUSH: begin
        if (fencei_done) begin
          flush_if = 1'b1;
          state_d  = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_issue_ctrl.sv
module tb_ysyx_23060124_issue_ctrl;
  import ysyx_23060124_issue_pkg::*;

  localparam int RW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0, in_wen = 1'b0, in_ctrl = 1'b0, in_fence_i = 1'b0;
  logic [RW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0, wb_rd = '0;
  logic          out_ready = 1'b0, wb_valid = 1'b0, redirect_valid = 1'b0, fencei_done = 1'b0;
  logic          in_ready, id_load, out_valid, icache_flush, flush_if;

  always #5 clock = ~clock;

  ysyx_23060124_issue_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_wen         (in_wen),
    .in_ctrl        (in_ctrl),
    .in_fence_i     (in_fence_i),
    .id_load        (id_load),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .redirect_valid (redirect_valid),
    .icache_flush   (icache_flush),
    .fencei_done    (fencei_done),
    .flush_if       (flush_if)
  );

  typedef struct {
    logic          rst, iv;
    logic [RW-1:0] rs1, rs2, rd;
    logic          wen, ctl, fi, ordy, wbv;
    logic [RW-1:0] wbrd;
    logic          rdr, fdn;
    logic          e_rdy, e_ov, e_icf, e_fif;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int iv, rs1, rs2, rd, wen, ctl, fi, ordy,
                              wbv, wbrd, rdr, fdn, e_rdy, e_ov, e_icf, e_fif);
    vec_t v;
    v.rst = 1'b0;     v.iv = iv[0];
    v.rs1 = rs1[RW-1:0]; v.rs2 = rs2[RW-1:0]; v.rd = rd[RW-1:0];
    v.wen = wen[0];   v.ctl = ctl[0]; v.fi = fi[0]; v.ordy = ordy[0];
    v.wbv = wbv[0];   v.wbrd = wbrd[RW-1:0];
    v.rdr = rdr[0];   v.fdn = fdn[0];
    v.e_rdy = e_rdy[0]; v.e_ov = e_ov[0]; v.e_icf = e_icf[0]; v.e_fif = e_fif[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after the edge, compare before the next one.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clock);
    #1;
    reset = v.rst; in_valid = v.iv; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    in_wen = v.wen; in_ctrl = v.ctl; in_fence_i = v.fi; out_ready = v.ordy;
    wb_valid = v.wbv; wb_rd = v.wbrd; redirect_valid = v.rdr; fencei_done = v.fdn;
    @(negedge clock);
    check({tag, " in_ready"},     {31'd0, in_ready},     {31'd0, v.e_rdy});
    check({tag, " id_load"},      {31'd0, id_load},      {31'd0, v.e_rdy});
    check({tag, " out_valid"},    {31'd0, out_valid},    {31'd0, v.e_ov});
    check({tag, " icache_flush"}, {31'd0, icache_flush}, {31'd0, v.e_icf});
    check({tag, " flush_if"},     {31'd0, flush_if},     {31'd0, v.e_fif});
    $display("%s: rst=%0d iv=%0d rd=%0d wb=%0d/%0d -> rdy=%0d ov=%0d icf=%0d fif=%0d",
             tag, v.rst, v.iv, v.rd, v.wbv, v.wbrd, in_ready, out_valid, icache_flush, flush_if);
  endtask

  task automatic check_counts_zero(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s cnt[%0d]", tag, i), {30'd0, dut.u_sb.cnt_q[i]}, 32'd0);
  endtask

  // Stimulus legality: a write-back must never target a register with no writer in flight.
  always @(negedge clock) begin
    if (reset === 1'b0 && wb_valid === 1'b1 && wb_rd != '0 && dut.u_sb.cnt_q[wb_rd] === 2'd0) begin
      n_bad++;
      $display("FAIL wb_underflow: wb_rd=%0d has count 0, required nonzero", wb_rd);
    end
  end

  initial begin
    vec_t v;

    // Columns: iv rs1 rs2 rd wen ctl fi ordy wbv wbrd rdr fdn | rdy ov icf fif
    // A: independent writes x1, x2, x3 back to back
    tbl.push_back(mk(1,0,0,1,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,2,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,1,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,2,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,3,0,0, 0,0,0,0));
    // B: write x5, reader of x5 stalls until the cycle after its write-back
    tbl.push_back(mk(1,0,0,5,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,5,0,6,1,0,0,1,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,5,6,1,0,0,1,1,5,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,5,6,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,6,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0, 0,0,0,0));
    // C: x7 writer saturation, plus same-cycle increment and decrement
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,1,7,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,7,1,0,0,1,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,7,0,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,7,0,0, 0,0,0,0));
    // D: jal x1 blocks issue until redirect; stray fencei_done/redirect ignored
    tbl.push_back(mk(1,0,0,1,1,1,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,2,1,0,0,1,0,0,0,1, 0,1,0,0));
    tbl.push_back(mk(1,0,0,2,1,0,0,1,1,1,0,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,2,1,0,0,1,0,0,1,0, 0,0,0,1));
    tbl.push_back(mk(1,0,0,2,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,2,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,1,0, 0,0,0,0));
    // E: fence.i with x8, x9 in flight; flush only after drain, then wait for done
    tbl.push_back(mk(1,0,0,8,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(1,0,0,9,1,0,0,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,1,1,0,0,0,0, 1,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,0,1,8,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,9,0,0, 0,1,0,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,1,0,0,0,0, 0,0,1,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,1,0,0,1,0, 0,0,0,0));
    tbl.push_back(mk(1,0,0,3,1,0,0,1,0,0,0,1, 0,0,0,1));
    tbl.push_back(mk(1,0,0,3,1,0,0,1,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,1,3,0,0, 0,1,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,1,0,0,0,0, 0,0,0,0));

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset in_ready",     {31'd0, in_ready},     32'd0);
    check("reset id_load",      {31'd0, id_load},      32'd0);
    check("reset out_valid",    {31'd0, out_valid},    32'd0);
    check("reset icache_flush", {31'd0, icache_flush}, 32'd0);
    check("reset flush_if",     {31'd0, flush_if},     32'd0);
    check("reset state",        {30'd0, dut.state_q},  {30'd0, ST_RUN});
    check_counts_zero("reset");

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));
    check_counts_zero("after table");

    // F: reset while in WAIT_CF with two x3 writers pending
    run_vec(mk(1,0,0,3,1,0,0,1,0,0,0,0, 1,0,0,0), "F1");
    run_vec(mk(1,0,0,3,1,0,0,1,0,0,0,0, 1,1,0,0), "F2");
    run_vec(mk(1,0,0,1,1,1,0,1,0,0,0,0, 1,1,0,0), "F3");
    run_vec(mk(1,0,0,4,1,0,0,0,0,0,0,0, 0,1,0,0), "F4");
    check("F4 state", {30'd0, dut.state_q}, {30'd0, ST_WAIT_CF});
    check("F4 cnt[3]", {30'd0, dut.u_sb.cnt_q[3]}, 32'd2);
    v = mk(1,0,0,4,1,0,0,0,0,0,0,0, 0,1,0,0);
    v.rst = 1'b1;
    run_vec(v, "F5");
    run_vec(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0), "F6");
    check("F6 state", {30'd0, dut.state_q}, {30'd0, ST_RUN});
    check_counts_zero("F6");
    run_vec(mk(1,0,0,4,1,0,0,1,0,0,0,0, 1,0,0,0), "F7");
    run_vec(mk(0,0,0,0,0,0,0,1,1,4,0,0, 0,1,0,0), "F8");
    run_vec(mk(0,0,0,0,0,0,0,1,0,0,0,0, 0,0,0,0), "F9");
    check_counts_zero("end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_issue_ctrl.md
# ysyx_23060124_issue_ctrl

Issue controller between the decoder and the execute stage. It owns the decode→execute valid bit, and tracks in-flight GPR writes in a per-register scoreboard so RAW and WAW-saturation hazards stall issue. It serialises control-flow instructions until their redirect resolves. It sequences `fence.i` by draining the pipeline, pulsing an I-cache flush and waiting for completion.

## Interface
- `NR_REGS`, default 16: architectural GPR count (RV32E); index width `RW = $clog2(NR_REGS)` = 4.
- `CNT_W`, default 2: width of each scoreboard counter, giving at most `2^CNT_W-1` writers in flight per register.

- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `in_valid`, in, 1: decoded instruction present.
- `in_ready`, out, 1: instruction accepted (issued) this cycle.
- `in_rs1`, `in_rs2`, `in_rd`, in, RW each: source and destination indices; 0 means none.
- `in_wen`, in, 1: instruction writes `in_rd`.
- `in_ctrl`, in, 1: OR of brch, jal, jalr, ecall, mret, ebreak.
- `in_fence_i`, in, 1: `fence.i`.
- `id_load`, out, 1: load enable for the external ID/EX payload register; equals `in_ready`.
- `out_valid`, out, 1: ID/EX register holds a valid instruction.
- `out_ready`, in, 1: EXU accepts.
- `wb_valid`, in, 1: a GPR write commits this cycle.
- `wb_rd`, in, RW: committed destination.
- `redirect_valid`, in, 1: control instruction resolved (1-cycle pulse).
- `icache_flush`, out, 1: 1-cycle flush request.
- `fencei_done`, in, 1: I-cache flush complete (pulse).
- `flush_if`, out, 1: discard the fetched and decoded instruction this cycle.

## Operation
- Slot free: `slot = !out_valid || out_ready`.
- Hazard: `hz = (rs1!=0 && cnt[rs1]!=0) || (rs2!=0 && cnt[rs2]!=0) || (in_wen && rd!=0 && cnt[rd]==max)`.
- Issue: `issue = in_valid && slot && !hz && state==RUN`. Drive `in_ready = id_load = issue`.
- `out_valid` next value: `issue ? 1 : (out_ready ? 0 : out_valid)`.
- Scoreboard:
  - Increment `cnt[in_rd]` on issue when `in_wen && in_rd!=0`.
  - Decrement `cnt[wb_rd]` on `wb_valid && wb_rd!=0`.
  - Increment and decrement of the same entry in one cycle: net unchanged.
  - Register 0 is never tracked.
  - Decrement at zero holds at 0; this is illegal stimulus and the bench asserts on it.
- Hazard check uses registered counts only; there is no same-cycle write-back bypass.
- FSM:
  - RUN: issue with `in_ctrl` → WAIT_CF. Issue with `in_fence_i` → DRAIN. Otherwise stay.
  - WAIT_CF: no issue. On `redirect_valid`, assert `flush_if` the same cycle → RUN.
  - DRAIN: no issue. When `!out_valid` and all counters are 0, assert `icache_flush` for 1 cycle → IFLUSH.
  - IFLUSH: no issue. On `fencei_done`, assert `flush_if` the same cycle → RUN.
- `redirect_valid` outside WAIT_CF and `fencei_done` outside IFLUSH are ignored.

## Timing
- Reset values: state = RUN, all `cnt` = 0, `out_valid` = 0. `in_ready`, `id_load`, `icache_flush` and `flush_if` are all 0.
- Reset mid-operation clears everything, pending counts included; the rest of the pipeline resets in the same cycle.
- Issue latency: `out_valid` rises the cycle after `in_ready`. Back-to-back issue at 1 per cycle when `out_ready` is held high and there are no hazards.
- RAW stall: a dependent instruction can issue at the earliest in the cycle after `wb_valid` for its producer.
- Control instruction: next issue at the earliest in the cycle after `redirect_valid`.
- `fence.i`:
  - `icache_flush` occurs at the earliest 1 cycle after drain completes.
  - The next issue occurs at the earliest the cycle after `fencei_done`.
- `in_valid` may drop without `in_ready`; no state is affected.
- `out_valid` stays high until `out_ready`.

## Structure
- Package `ysyx_23060124_issue_pkg`: FSM state enum {RUN, WAIT_CF, DRAIN, IFLUSH}, `NR_REGS`, `RW`, `CNT_W` defaults.
- Sub-module `ysyx_23060124_scoreboard`:
  - Holds the counter array.
  - Ports: inc port, dec port, two read ports, rd-saturated flag, all-zero flag.
- The top level holds the FSM, the `out_valid` register and the issue logic.

## Test plan
- Independent ALU ops x1→x2→x3, `out_ready`=1 → `in_ready` high 3 consecutive cycles, `out_valid` high cycles 1–3.
- Issue writes x5, then a reader of x5 → stall. Pulse `wb_valid`, `wb_rd`=5 at cycle N → reader issues at cycle N+1; `cnt[5]` returns to 0.
- 3 writes to x7 without write-back (`CNT_W`=2) → a 4th x7 writer stalls until one `wb_valid` `wb_rd`=7.
- Issue jal → no issue while `in_valid`=1. `redirect_valid` at cycle N → `flush_if`=1 at N, issue resumes at N+1.
- `fence.i` with 2 writes in flight → `icache_flush` only after both write-backs and `out_valid`=0. `fencei_done` → `flush_if` pulse and return to RUN.
- Assert `reset` in WAIT_CF with `cnt[3]`=2 → next cycle state RUN, all counters 0, `out_valid`=0.
